// File: rtl/i2c_codec_responder.sv
// I2C write-only target for 3-byte codec register writes (7-bit reg address, 9-bit data).
// Samples SCL/SDA through synchronizers, ACKs matched bytes and strobes each committed write.
module i2c_codec_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_sclk,
  input  logic       i_sdat,
  output logic       o_sdat,
  output logic       o_oen,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_BYTE1, S_ACK1, S_BYTE2, S_ACK2, S_WAIT_STOP
  } state_t;

  // Synchronizers reset to the idle-bus level so reset release never looks like an edge.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_sclk};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], i_sdat};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, byte1_q, byte1_d, byte_in;
  logic       skip_q, skip_d, err_seen_q, err_seen_d;
  logic       oen_q, oen_d, busy_q, busy_d, wr_valid_q, wr_valid_d, err_q, err_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [8:0] wr_data_q, wr_data_d;

  assign byte_in = {shift_q[6:0], sda_s};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte1_d    = byte1_q;
    skip_d     = skip_q;
    oen_d      = oen_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (stop_det) begin
      err_d     = !(state_q inside {S_IDLE, S_WAIT_STOP});
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      oen_d     = 1'b0;
      bit_cnt_d = '0;
      skip_d    = 1'b0;
    end else if (start_det) begin
      err_d     = state_q inside {S_BYTE1, S_ACK1, S_BYTE2, S_ACK2};
      state_d   = S_ADDR;
      busy_d    = 1'b1;
      oen_d     = 1'b0;
      bit_cnt_d = '0;
      skip_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_BYTE1, S_BYTE2, S_WAIT_STOP: begin
          // skip_q swallows the ACK clock of a byte we declined to acknowledge
          if (scl_rise && skip_q) begin
            skip_d = 1'b0;
          end else if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_ADDR: begin
                  if (byte_in == {DEV_ADDR, 1'b0}) begin
                    state_d = S_ADDR_ACK;
                  end else begin
                    state_d = S_WAIT_STOP;
                    err_d   = 1'b1;
                    skip_d  = 1'b1;
                  end
                end
                S_BYTE1: begin
                  byte1_d = byte_in;
                  state_d = S_ACK1;
                end
                S_BYTE2: state_d = S_ACK2;
                default: begin
                  err_d  = !err_seen_q;
                  skip_d = 1'b1;
                end
              endcase
            end
          end
        end
        S_ADDR_ACK, S_ACK1, S_ACK2: begin
          // First fall starts driving the ACK, second fall ends the 9th clock.
          if (scl_fall && !oen_q) begin
            oen_d = 1'b1;
          end else if (scl_fall) begin
            oen_d = 1'b0;
            case (state_q)
              S_ADDR_ACK: state_d = S_BYTE1;
              S_ACK1:     state_d = S_BYTE2;
              default: begin
                state_d    = S_WAIT_STOP;
                wr_addr_d  = byte1_q[7:1];
                wr_data_d  = {byte1_q[0], shift_q};
                wr_valid_d = 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
    err_seen_d = (start_det || stop_det) ? 1'b0 : (err_seen_q | err_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte1_q    <= '0;
      skip_q     <= 1'b0;
      err_seen_q <= 1'b0;
      oen_q      <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte1_q    <= byte1_d;
      skip_q     <= skip_d;
      err_seen_q <= err_seen_d;
      oen_q      <= oen_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_sdat     = 1'b0;
  assign o_oen      = oen_q;
  assign o_busy     = busy_q;
  assign o_wr_valid = wr_valid_q;
  assign o_err      = err_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: an I2C master drives frames; a frame-level model predicts ACKs,
// commits and error pulses.
module tb_i2c_codec_responder;
  localparam int H = 8;
  localparam logic [6:0] DEV = 7'h1A;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       o_sdat, o_oen, o_wr_valid, o_busy, o_err;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull SDA low.
  assign sda_line = sda_m & ~(o_oen & ~o_sdat);

  i2c_codec_responder #(.DEV_ADDR(DEV), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(scl_m), .i_sdat(sda_line),
    .o_sdat(o_sdat), .o_oen(o_oen), .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .o_busy(o_busy), .o_err(o_err)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int   wr_cnt = 0, err_cnt = 0, ack_cnt = 0;
  logic oen_prev = 1'b0;

  always @(negedge clk) begin
    if (o_wr_valid) wr_cnt++;
    if (o_err) err_cnt++;
    if (o_oen && !oen_prev) ack_cnt++;
    oen_prev = o_oen;
  end

  logic [7:0] fb [0:7];
  logic [6:0] exp_addr = '0;
  logic [8:0] exp_data = '0;
  bit         in_frame = 1'b0;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(H);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rst_mid, output bit ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clk(H);
      scl_m = 1'b1; wait_clk(H);
      scl_m = 1'b0; wait_clk(H);
    end
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H / 2);
    ack = !sda_line;
    if (rst_mid) begin
      chk("oen_before_rst", int'(o_oen), 1);
      rst_n = 1'b0;
      #1;
      chk("oen_async_drop", int'(o_oen), 0);
      chk("busy_in_rst", int'(o_busy), 0);
      chk("wr_valid_in_rst", int'(o_wr_valid), 0);
      wait_clk(2);
      rst_n = 1'b1;
    end
    wait_clk(H / 2);
    scl_m = 1'b0; wait_clk(H);
  endtask

  // Frame model: a matched write address is ACKed for at most 3 bytes; 3 bytes commit a write;
  // a NACKed tail gives one error; leaving a partial write (after the address ACK) gives one error.
  task automatic run_frame(input int n, input bit restart);
    int  w0, e0, a0, exp_err, nack, exp_wr;
    bit  ack, exp_ack, addr_ok;
    w0 = wr_cnt; e0 = err_cnt; a0 = ack_cnt; nack = 0;
    if (!in_frame) do_start();
    in_frame = 1'b1;
    chk("busy_in_frame", int'(o_busy), 1);
    addr_ok = (fb[0] == {DEV, 1'b0});
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], 1'b0, ack);
      exp_ack = addr_ok && (i < 3);
      chk("ack_bit", int'(ack), int'(exp_ack));
      if (exp_ack) nack++;
    end
    if (addr_ok) exp_err = ((n > 3) ? 1 : 0) + ((n == 1 || n == 2) ? 1 : 0);
    else exp_err = 1;
    exp_wr = (addr_ok && n >= 3) ? 1 : 0;
    if (exp_wr == 1) begin
      exp_addr = fb[1][7:1];
      exp_data = {fb[1][0], fb[2]};
    end
    if (restart) do_start();
    else begin
      do_stop();
      in_frame = 1'b0;
    end
    wait_clk(4);
    chk("wr_count", wr_cnt - w0, exp_wr);
    chk("err_count", err_cnt - e0, exp_err);
    chk("ack_pulses", ack_cnt - a0, nack);
    chk("wr_addr", int'(o_wr_addr), int'(exp_addr));
    chk("wr_data", int'(o_wr_data), int'(exp_data));
    chk("busy_after", int'(o_busy), restart ? 1 : 0);
    $display("frame n=%0d bytes=%h %h %h %h restart=%0d wr=%0d err=%0d addr=%h data=%h",
             n, fb[0], fb[1], fb[2], fb[3], restart, wr_cnt - w0, err_cnt - e0, o_wr_addr, o_wr_data);
  endtask

  task automatic set_fb(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = 8'h00;
  endtask

  initial begin
    bit ack;
    int w0, e0, sel, n;
    wait_clk(3);
    chk("rst_outputs", int'({o_sdat, o_oen, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_err}), 0);
    rst_n = 1'b1;
    wait_clk(4);
    chk("idle_busy", int'(o_busy), 0);

    set_fb(8'h34, 8'h00, 8'h97); run_frame(3, 1'b0);
    set_fb(8'h34, 8'h1E, 8'h00); run_frame(3, 1'b0);
    set_fb(8'h34, 8'h12, 8'h01); run_frame(3, 1'b0);
    set_fb(8'h36, 8'h12, 8'h01); run_frame(3, 1'b0);
    set_fb(8'h35, 8'h00, 8'h00); run_frame(1, 1'b0);
    set_fb(8'h34, 8'h08, 8'h19); run_frame(3, 1'b0);
    set_fb(8'h34, 8'h0E, 8'h00); run_frame(2, 1'b1);
    set_fb(8'h34, 8'h10, 8'h42); run_frame(3, 1'b0);

    // Reset during ACK1 discards the write and clears the held outputs.
    w0 = wr_cnt;
    do_start();
    send_byte(8'h34, 1'b0, ack);
    chk("rst_case_addr_ack", int'(ack), 1);
    send_byte(8'h1E, 1'b1, ack);
    do_stop();
    wait_clk(4);
    e0 = err_cnt;
    chk("rst_case_wr_count", wr_cnt - w0, 0);
    chk("rst_case_busy", int'(o_busy), 0);
    exp_addr = '0;
    exp_data = '0;
    chk("rst_case_addr_clr", int'(o_wr_addr), 0);
    $display("reset-in-ack1 frame wr=%0d", wr_cnt - w0);
    set_fb(8'h34, 8'hA5, 8'h3C); run_frame(3, 1'b0);
    chk("post_rst_err_total", err_cnt - e0, 0);

    for (int k = 0; k < 25; k++) begin
      sel = $urandom_range(0, 9);
      fb[0] = (sel < 6) ? 8'h34 : (sel == 6) ? 8'h35 : (sel == 7) ? 8'h36 : 8'($urandom);
      for (int j = 1; j < 8; j++) fb[j] = 8'($urandom);
      n = $urandom_range(1, 4);
      run_frame(n, ($urandom_range(0, 3) == 0));
    end
    if (in_frame) begin
      do_stop();
      wait_clk(4);
      chk("final_busy", int'(o_busy), 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
